// File: rtl/nv_nvdla_cacc_abuf_rd_arb.sv
// Assembly-buffer read arbiter: accumulation has fixed priority over delivery, and a
// starvation FSM raises accu_stall. Optional conflict counter: NVDLA_CACC_ABUF_RD_ARB_PERF_EN.
module nv_nvdla_cacc_abuf_rd_arb #(
    parameter int ABUF_AWIDTH = 6,
    parameter int RD_LAT      = 2,
    parameter int STARVE_MAX  = 8
) (
    input  logic                   nvdla_core_clk,
    input  logic                   nvdla_core_rst,
    input  logic                   accu_rd_en,
    input  logic [ABUF_AWIDTH-1:0] accu_rd_addr,
    input  logic                   dlv_rd_req_vld,
    input  logic [ABUF_AWIDTH-1:0] dlv_rd_req_addr,
    output logic                   dlv_rd_req_rdy,
    output logic                   abuf_rd_en,
    output logic [ABUF_AWIDTH-1:0] abuf_rd_addr,
    output logic                   accu_rd_dat_vld,
    output logic                   dlv_rd_dat_vld,
    output logic                   accu_stall,
    output logic                   err_starve_viol,
    input  logic                   perf_clr,
    output logic [15:0]            dp2reg_abuf_conflict_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STARVE} state_t;

    state_t      state, nxt_state;
    logic [3:0]  cnt, nxt_cnt;
    logic        blocked, dlv_hs;
    logic [RD_LAT:1] vld_pipe, src_pipe;

    assign dlv_rd_req_rdy = ~accu_rd_en;
    assign abuf_rd_en     = accu_rd_en | dlv_rd_req_vld;
    assign abuf_rd_addr   = accu_rd_en ? accu_rd_addr : dlv_rd_req_addr;
    assign blocked        = dlv_rd_req_vld & accu_rd_en;
    assign dlv_hs         = dlv_rd_req_vld & dlv_rd_req_rdy;

    // Source tag travels alongside the read so returning data can be steered.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            vld_pipe <= '0;
            src_pipe <= '0;
        end else begin
            vld_pipe[1] <= abuf_rd_en;
            src_pipe[1] <= accu_rd_en;
            for (int i = 2; i <= RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                src_pipe[i] <= src_pipe[i-1];
            end
        end
    end

    assign accu_rd_dat_vld = vld_pipe[RD_LAT] & src_pipe[RD_LAT];
    assign dlv_rd_dat_vld  = vld_pipe[RD_LAT] & ~src_pipe[RD_LAT];

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        case (state)
            S_IDLE: begin
                if (blocked) begin
                    nxt_state = S_WAIT;
                    nxt_cnt   = 4'd1;
                end
            end
            S_WAIT: begin
                if (!dlv_rd_req_vld || dlv_hs) begin
                    nxt_state = S_IDLE;
                    nxt_cnt   = '0;
                end else if (cnt == 4'(STARVE_MAX - 1)) begin
                    nxt_state = S_STARVE;
                end else begin
                    nxt_cnt = cnt + 4'd1;
                end
            end
            S_STARVE: begin
                if (!dlv_rd_req_vld || dlv_hs) begin
                    nxt_state = S_IDLE;
                    nxt_cnt   = '0;
                end
            end
            default: begin
                nxt_state = S_IDLE;
                nxt_cnt   = '0;
            end
        endcase
    end

    // state is a flop, so the stall seen upstream is glitch-free.
    assign accu_stall = (state == S_STARVE);

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst)
            err_starve_viol <= 1'b0;
        else if (accu_rd_en && accu_stall)
            err_starve_viol <= 1'b1;
    end

`ifdef NVDLA_CACC_ABUF_RD_ARB_PERF_EN
    logic [15:0] conflict_cnt;

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst || perf_clr)
            conflict_cnt <= '0;
        else if (blocked && conflict_cnt != 16'hFFFF)
            conflict_cnt <= conflict_cnt + 16'd1;
    end

    assign dp2reg_abuf_conflict_cnt = conflict_cnt;
`else
    logic unused_perf_clr;
    assign unused_perf_clr          = perf_clr;
    assign dp2reg_abuf_conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_nv_nvdla_cacc_abuf_rd_arb.sv
// Scoreboard bench for nv_nvdla_cacc_abuf_rd_arb: grants push expected data returns,
// a negedge monitor pops and checks them; state outputs are checked inline.
module tb_nv_nvdla_cacc_abuf_rd_arb;
    localparam int AW = 6;
    localparam int RD_LAT = 2;
`ifdef NVDLA_CACC_ABUF_RD_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic accu_rd_en, dlv_rd_req_vld, perf_clr;
    logic [AW-1:0] accu_rd_addr, dlv_rd_req_addr;
    logic dlv_rd_req_rdy, abuf_rd_en, accu_rd_dat_vld, dlv_rd_dat_vld;
    logic accu_stall, err_starve_viol;
    logic [AW-1:0] abuf_rd_addr;
    logic [15:0] cnt;

    nv_nvdla_cacc_abuf_rd_arb #(.ABUF_AWIDTH(AW), .RD_LAT(RD_LAT), .STARVE_MAX(8)) dut (
        .nvdla_core_clk(clk), .nvdla_core_rst(rst),
        .accu_rd_en(accu_rd_en), .accu_rd_addr(accu_rd_addr),
        .dlv_rd_req_vld(dlv_rd_req_vld), .dlv_rd_req_addr(dlv_rd_req_addr),
        .dlv_rd_req_rdy(dlv_rd_req_rdy), .abuf_rd_en(abuf_rd_en), .abuf_rd_addr(abuf_rd_addr),
        .accu_rd_dat_vld(accu_rd_dat_vld), .dlv_rd_dat_vld(dlv_rd_dat_vld),
        .accu_stall(accu_stall), .err_starve_viol(err_starve_viol),
        .perf_clr(perf_clr), .dp2reg_abuf_conflict_cnt(cnt)
    );

    always #5 clk = ~clk;

    typedef struct { int due; bit src; } exp_t;
    exp_t sbq[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every data return must match the oldest outstanding grant.
    always @(negedge clk) begin
        exp_t e;
        if (accu_rd_dat_vld || dlv_rd_dat_vld) begin
            checks++;
            if (accu_rd_dat_vld && dlv_rd_dat_vld) begin
                errors++;
                $display("FAIL dat_vld_both: both valids high at cycle %0d", cyc);
            end else if (sbq.size() == 0) begin
                errors++;
                $display("FAIL dat_vld_unexpected: accu=%0b dlv=%0b at cycle %0d, none expected",
                         accu_rd_dat_vld, dlv_rd_dat_vld, cyc);
            end else begin
                e = sbq.pop_front();
                if (e.due != cyc || e.src != accu_rd_dat_vld) begin
                    errors++;
                    $display("FAIL dat_return: got cycle %0d src_accu %0b, expected cycle %0d src_accu %0b",
                             cyc, accu_rd_dat_vld, e.due, e.src);
                end
            end
        end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
            checks++;
            errors++;
            e = sbq.pop_front();
            $display("FAIL dat_missing: got nothing at cycle %0d, expected src_accu %0b due %0d",
                     cyc, e.src, e.due);
        end
    end

    // One cycle of stimulus; combinational outputs checked right after the inputs settle.
    task automatic drive(input bit a, input logic [AW-1:0] aa, input bit d,
                         input logic [AW-1:0] da, input bit clr, input bit r);
        exp_t keep[$];
        @(posedge clk);
        #1;
        rst = r; accu_rd_en = a; accu_rd_addr = aa;
        dlv_rd_req_vld = d; dlv_rd_req_addr = da; perf_clr = clr;
        if (r) begin
            foreach (sbq[i]) if (sbq[i].due <= cyc) keep.push_back(sbq[i]);
            sbq = keep;
        end else if (a || d) begin
            sbq.push_back('{cyc + RD_LAT, a});
        end
        #1;
        chk("abuf_rd_en", abuf_rd_en, a | d);
        chk("dlv_rd_req_rdy", dlv_rd_req_rdy, !a);
        if (a || d) chk("abuf_rd_addr", abuf_rd_addr, a ? aa : da);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; accu_rd_en = 0; accu_rd_addr = 0; dlv_rd_req_vld = 0;
        dlv_rd_req_addr = 0; perf_clr = 0;
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 1);
        chk("rst_stall", accu_stall, 0);
        chk("rst_err", err_starve_viol, 0);
        chk("rst_cnt", cnt, 0);
        idle(2);

        // Collision: accumulation wins, delivery waits.
        drive(1, 6'd5, 1, 6'd9, 0, 0);
        idle(3);
        // Delivery alone at top address.
        drive(0, 0, 1, 6'h3F, 0, 0);
        idle(3);
        // Back-to-back alternating grants.
        drive(1, 6'd1, 0, 0, 0, 0);
        drive(0, 0, 1, 6'd2, 0, 0);
        drive(1, 6'd3, 0, 0, 0, 0);
        drive(0, 0, 1, 6'd4, 0, 0);
        idle(3);

        // Starvation: 8 blocked cycles, stall appears on the 9th.
        for (int i = 1; i <= 8; i++) begin
            drive(1, 6'(i), 1, 6'h2A, 0, 0);
            chk("stall_pre", accu_stall, 0);
        end
        drive(1, 6'd7, 1, 6'h2A, 0, 0);
        chk("stall_on", accu_stall, 1);
        chk("err_before", err_starve_viol, 0);
        drive(0, 0, 1, 6'h2A, 0, 0);
        chk("stall_hs_cycle", accu_stall, 1);
        chk("err_set", err_starve_viol, 1);
        idle(1);
        chk("stall_off", accu_stall, 0);
        chk("err_sticky", err_starve_viol, 1);
        chk("cnt_10", cnt, PERF ? 10 : 0);

        // perf_clr wins over a simultaneous blocked cycle.
        drive(1, 6'd0, 1, 6'd1, 1, 0);
        idle(1);
        chk("cnt_clr", cnt, 0);
        for (int i = 0; i < 20; i++) drive(1, 6'd8, 1, 6'd9, 0, 0);
        idle(1);
        chk("cnt_20", cnt, PERF ? 20 : 0);
        chk("err_still", err_starve_viol, 1);
        drive(0, 0, 0, 0, 1, 0);
        idle(2);
        chk("cnt_clr2", cnt, 0);

        // Reset with tags in flight while starved.
        for (int i = 0; i < 9; i++) drive(1, 6'd12, 1, 6'd13, 0, 0);
        chk("stall_pre_rst", accu_stall, 1);
        drive(0, 0, 1, 6'h11, 0, 1);
        drive(0, 0, 0, 0, 0, 0);
        chk("rst_mid_stall", accu_stall, 0);
        chk("rst_mid_err", err_starve_viol, 0);
        chk("rst_mid_cnt", cnt, 0);
        idle(1);
        // FSM back in IDLE: a fresh single collision must not stall.
        drive(1, 6'd2, 1, 6'd3, 0, 0);
        idle(1);
        chk("post_rst_stall", accu_stall, 0);
        idle(4);
        chk("sb_empty", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
